// File: rtl/move_input_ctrl_pkg.sv
// chess_pkg: piece codes, the square type, the move FSM state enum and
// colour helpers shared by the move-input controller and its interface.
package chess_pkg;

  typedef logic [5:0] square_t;  // [5:3] row, [2:0] col

  localparam logic [3:0] EMPTY    = 4'h0;
  localparam logic [3:0] W_PAWN   = 4'h1;
  localparam logic [3:0] W_KNIGHT = 4'h2;
  localparam logic [3:0] W_BISHOP = 4'h3;
  localparam logic [3:0] W_ROOK   = 4'h4;
  localparam logic [3:0] W_QUEEN  = 4'h5;
  localparam logic [3:0] W_KING   = 4'h6;
  localparam logic [3:0] B_PAWN   = 4'h7;
  localparam logic [3:0] B_KNIGHT = 4'h8;
  localparam logic [3:0] B_BISHOP = 4'h9;
  localparam logic [3:0] B_ROOK   = 4'hA;
  localparam logic [3:0] B_QUEEN  = 4'hB;
  localparam logic [3:0] B_KING   = 4'hC;
  localparam logic [3:0] MARK     = 4'hD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUERY = 3'd1,
    CHECK = 3'd2,
    PICK  = 3'd3,
    HOLD  = 3'd4,
    PLACE = 3'd5
  } move_state_t;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= W_PAWN) && (code <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// move_input_ctrl_if: bundle between the mouse front end / board store and
// the move-input controller.
//   master : controller view (mouse, board lookup and legal-move inputs in;
//            query, pick/place commands and status out)
//   slave  : environment view (mirror of master)
interface move_input_ctrl_if;
  logic                   mouse_left;
  logic [11:0]            xpos;
  logic [11:0]            ypos;
  logic [3:0]             query_code;
  logic [63:0]            possible_moves;
  logic                   game_over;
  chess_pkg::square_t     query_xy;
  chess_pkg::square_t     figure_position;
  logic                   pick_piece;
  logic                   place_piece;
  logic                   holding;
  chess_pkg::square_t     sel_pos;
  logic                   white_turn;

  modport master (
    input  mouse_left, xpos, ypos, query_code, possible_moves, game_over,
    output query_xy, figure_position, pick_piece, place_piece, holding,
           sel_pos, white_turn
  );

  modport slave (
    output mouse_left, xpos, ypos, query_code, possible_moves, game_over,
    input  query_xy, figure_position, pick_piece, place_piece, holding,
           sel_pos, white_turn
  );
endinterface

// File: rtl/move_input_ctrl_pixel_to_square.sv
// pixel_to_square: combinational map from a mouse pixel to a board square.
//   xpos, ypos : pixel coordinates
//   sq         : {row, col} of the square under the pointer
//   valid      : pointer lies inside the 8x8 board
module pixel_to_square
  import chess_pkg::*;
#(
  parameter int BOARD_X0 = 192,
  parameter int BOARD_Y0 = 112,
  parameter int SQ_SHIFT = 6
) (
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output square_t     sq,
  output logic        valid
);
  localparam logic [11:0] X0 = 12'(BOARD_X0);
  localparam logic [11:0] Y0 = 12'(BOARD_Y0);

  logic [11:0] dx, dy, col, row;

  // Subtraction wraps for pixels left/above the board; the >= tests reject those.
  assign dx  = xpos - X0;
  assign dy  = ypos - Y0;
  assign col = dx >> SQ_SHIFT;
  assign row = dy >> SQ_SHIFT;

  assign valid = (xpos >= X0) && (ypos >= Y0) && (col < 12'd8) && (row < 12'd8);
  assign sq    = {row[2:0], col[2:0]};
endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: turns mouse clicks into 1-cycle pick/place pulses for the
// board store, enforcing side to move and legal destinations.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : move_input_ctrl_if.master (mouse, board lookup, commands)
// Optional feature: define MOVE_TIMEOUT_EN to cancel a held move after
// TIMEOUT_CYCLES cycles in HOLD.
module move_input_ctrl
  import chess_pkg::*;
#(
  parameter int BOARD_X0       = 192,
  parameter int BOARD_Y0       = 112,
  parameter int SQ_SHIFT       = 6,
  parameter int TIMEOUT_CYCLES = 65_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  move_input_ctrl_if.master  bus
);
  move_state_t state_reg, state_next;
  square_t     cand_reg, cand_next;
  square_t     query_xy_reg, query_xy_next;
  square_t     fig_pos_reg, fig_pos_next;
  square_t     sel_pos_reg, sel_pos_next;
  logic        holding_reg, holding_next;
  logic        white_turn_reg, white_turn_next;
  logic        cancel_reg, cancel_next;
  logic        mouse_prev_reg;
  logic        click;
  square_t     click_sq;
  logic        click_sq_valid;

  pixel_to_square #(
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0),
    .SQ_SHIFT (SQ_SHIFT)
  ) u_pixel_to_square (
    .xpos  (bus.xpos),
    .ypos  (bus.ypos),
    .sq    (click_sq),
    .valid (click_sq_valid)
  );

  // A press counts once, on its first cycle, however long it is held.
  assign click = bus.mouse_left & ~mouse_prev_reg;

`ifdef MOVE_TIMEOUT_EN
  localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYCLES - 1);
  logic [26:0] tmo_cnt_reg, tmo_cnt_next;

  // Zero outside HOLD, so it is already clear on entry to HOLD.
  always_comb begin
    tmo_cnt_next = '0;
    if (state_reg == HOLD) tmo_cnt_next = tmo_cnt_reg + 27'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_reg <= '0;
    else        tmo_cnt_reg <= tmo_cnt_next;
  end
`endif

  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    query_xy_next   = query_xy_reg;
    fig_pos_next    = fig_pos_reg;
    sel_pos_next    = sel_pos_reg;
    holding_next    = holding_reg;
    white_turn_next = white_turn_reg;
    cancel_next     = cancel_reg;

    case (state_reg)
      IDLE: begin
        if (click && click_sq_valid && !bus.game_over) begin
          cand_next     = click_sq;
          query_xy_next = click_sq;
          state_next    = QUERY;
        end
      end
      QUERY: state_next = CHECK;  // board store registers query_code this cycle
      CHECK: begin
        if (white_turn_reg ? is_white(bus.query_code) : is_black(bus.query_code)) begin
          fig_pos_next = cand_reg;
          state_next   = PICK;
        end else begin
          state_next = IDLE;
        end
      end
      PICK: begin
        sel_pos_next = cand_reg;
        holding_next = 1'b1;
        state_next   = HOLD;
      end
      HOLD: begin
        if (click && click_sq_valid) begin
          if (click_sq == sel_pos_reg) begin
            fig_pos_next = click_sq;
            cancel_next  = 1'b1;
            state_next   = PLACE;
          end else if (bus.possible_moves[click_sq]) begin
            fig_pos_next = click_sq;
            cancel_next  = 1'b0;
            state_next   = PLACE;
          end
        end
`ifdef MOVE_TIMEOUT_EN
        // Timeout wins over a same-cycle click: the piece goes back home.
        if (tmo_cnt_reg == TO_LAST) begin
          fig_pos_next = sel_pos_reg;
          cancel_next  = 1'b1;
          state_next   = PLACE;
        end
`endif
      end
      PLACE: begin
        holding_next = 1'b0;
        if (!cancel_reg) white_turn_next = ~white_turn_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cand_reg       <= '0;
      query_xy_reg   <= '0;
      fig_pos_reg    <= '0;
      sel_pos_reg    <= '0;
      holding_reg    <= 1'b0;
      white_turn_reg <= 1'b1;
      cancel_reg     <= 1'b0;
      mouse_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      query_xy_reg   <= query_xy_next;
      fig_pos_reg    <= fig_pos_next;
      sel_pos_reg    <= sel_pos_next;
      holding_reg    <= holding_next;
      white_turn_reg <= white_turn_next;
      cancel_reg     <= cancel_next;
      mouse_prev_reg <= bus.mouse_left;
    end
  end

  assign bus.query_xy        = query_xy_reg;
  assign bus.figure_position = fig_pos_reg;
  assign bus.pick_piece      = (state_reg == PICK);
  assign bus.place_piece     = (state_reg == PLACE);
  assign bus.holding         = holding_reg;
  assign bus.sel_pos         = sel_pos_reg;
  assign bus.white_turn      = white_turn_reg;
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: directed self-checking bench for move_input_ctrl.
// A small board model answers query_xy one cycle later; a negedge monitor
// counts pick/place pulses and records their square and cycle.
module tb_move_input_ctrl;
  import chess_pkg::*;

`ifdef MOVE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65_000_000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  move_input_ctrl_if bus ();

  move_input_ctrl #(
    .BOARD_X0       (192),
    .BOARD_Y0       (112),
    .SQ_SHIFT       (6),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [3:0] board_mem [64];
  always @(posedge clk) bus.query_code <= board_mem[bus.query_xy];

  int cyc = 0;
  int pick_cnt = 0, place_cnt = 0, both_cnt = 0;
  int pick_cyc = 0, place_cyc = 0;
  logic [5:0] pick_pos = '0, place_pos = '0;
  int errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pick_piece) begin
      pick_cnt <= pick_cnt + 1; pick_pos <= bus.figure_position; pick_cyc <= cyc;
    end
    if (bus.place_piece) begin
      place_cnt <= place_cnt + 1; place_pos <= bus.figure_position; place_cyc <= cyc;
    end
    if (bus.pick_piece && bus.place_piece) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int click_cyc = 0;

  // Press for one cycle at (x,y), release, then let the FSM settle.
  task automatic click(input int x, input int y);
    @(posedge clk); #1;
    bus.xpos = 12'(x); bus.ypos = 12'(y); bus.mouse_left = 1'b1;
    click_cyc = cyc;
    @(posedge clk); #1;
    bus.mouse_left = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("click (%0d,%0d): picks=%0d places=%0d holding=%0d white_turn=%0d",
             x, y, pick_cnt, place_cnt, bus.holding, bus.white_turn);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int p0, q0;

  initial begin
    for (int i = 0; i < 64; i++) board_mem[i] = EMPTY;
    board_mem[52] = W_PAWN;
    board_mem[20] = B_PAWN;
    board_mem[44] = MARK;
    board_mem[7]  = W_ROOK;
    bus.mouse_left = 1'b0; bus.xpos = '0; bus.ypos = '0;
    bus.possible_moves = '0; bus.game_over = 1'b0;

    // Reset values
    do_reset();
    check("rst_holding", 64'(bus.holding), 64'd0);
    check("rst_white_turn", 64'(bus.white_turn), 64'd1);
    check("rst_pick", 64'(bus.pick_piece), 64'd0);
    check("rst_place", 64'(bus.place_piece), 64'd0);
    check("rst_figpos", 64'(bus.figure_position), 64'd0);
    check("rst_selpos", 64'(bus.sel_pos), 64'd0);
    check("rst_query", 64'(bus.query_xy), 64'd0);

    // 1: pick the e2 pawn
    click(458, 506);
    check("t1_pick_cnt", 64'(pick_cnt), 64'd1);
    check("t1_pick_pos", 64'(pick_pos), 64'd52);
    check("t1_latency", 64'(pick_cyc - click_cyc), 64'd3);
    check("t1_holding", 64'(bus.holding), 64'd1);
    check("t1_selpos", 64'(bus.sel_pos), 64'd52);
    check("t1_query", 64'(bus.query_xy), 64'd52);
    check("t1_no_place", 64'(place_cnt), 64'd0);

    // 2: legal move to e4
    bus.possible_moves = 64'd1 << 36;
    click(458, 378);
    check("t2_place_cnt", 64'(place_cnt), 64'd1);
    check("t2_place_pos", 64'(place_pos), 64'd36);
    check("t2_white_turn", 64'(bus.white_turn), 64'd0);
    check("t2_holding", 64'(bus.holding), 64'd0);
    repeat (5) @(posedge clk); #1;
    check("t2_figpos_held", 64'(bus.figure_position), 64'd36);

    // Black to move: white pawn ignored, black pawn picked, then cancelled
    click(458, 506);
    check("bt_white_ignored", 64'(pick_cnt), 64'd1);
    click(458, 250);
    check("bt_black_pick", 64'(pick_cnt), 64'd2);
    check("bt_black_pos", 64'(pick_pos), 64'd20);
    click(458, 250);
    check("bt_cancel_cnt", 64'(place_cnt), 64'd2);
    check("bt_cancel_pos", 64'(place_pos), 64'd20);
    check("bt_cancel_turn", 64'(bus.white_turn), 64'd0);

    // 3: white to move, opponent / empty / marker squares ignored
    do_reset();
    p0 = pick_cnt;
    click(458, 250);
    check("t3_black_nopick", 64'(pick_cnt), 64'(p0));
    check("t3_black_hold", 64'(bus.holding), 64'd0);
    click(458, 378);
    check("t3_empty_nopick", 64'(pick_cnt), 64'(p0));
    click(458, 442);
    check("t3_mark_nopick", 64'(pick_cnt), 64'(p0));
    click(458, 506);
    check("t3_idle_pick", 64'(pick_cnt), 64'(p0 + 1));
    check("t3_idle_pos", 64'(pick_pos), 64'd52);

    // 4: illegal destination ignored, then cancel on origin
    q0 = place_cnt;
    bus.possible_moves = 64'd1 << 36;
    click(458, 250);
    check("t4_illegal_noplace", 64'(place_cnt), 64'(q0));
    check("t4_still_holding", 64'(bus.holding), 64'd1);
    click(458, 506);
    check("t4_cancel_cnt", 64'(place_cnt), 64'(q0 + 1));
    check("t4_cancel_pos", 64'(place_pos), 64'd52);
    check("t4_turn_kept", 64'(bus.white_turn), 64'd1);
    check("t4_released", 64'(bus.holding), 64'd0);

    // 5: out-of-board clicks, board corner, long press, game_over
    p0 = pick_cnt;
    click(100, 100);
    click(800, 700);
    click(191, 506);
    click(704, 506);
    check("t5_offboard", 64'(pick_cnt), 64'(p0));
    click(703, 112);
    check("t5_corner_pick", 64'(pick_cnt), 64'(p0 + 1));
    check("t5_corner_pos", 64'(pick_pos), 64'd7);
    click(703, 112);
    check("t5_corner_cancel", 64'(place_pos), 64'd7);
    p0 = pick_cnt; q0 = place_cnt;
    @(posedge clk); #1;
    bus.xpos = 12'd458; bus.ypos = 12'd506; bus.mouse_left = 1'b1;
    repeat (1000) @(posedge clk);
    #1 bus.mouse_left = 1'b0;
    repeat (6) @(posedge clk); #1;
    $display("long press: picks=%0d places=%0d", pick_cnt, place_cnt);
    check("t5_long_one_pick", 64'(pick_cnt), 64'(p0 + 1));
    check("t5_long_no_place", 64'(place_cnt), 64'(q0));
    bus.game_over = 1'b1;
    click(458, 378);
    check("t5_go_place", 64'(place_cnt), 64'(q0 + 1));
    check("t5_go_place_pos", 64'(place_pos), 64'd36);
    check("t5_go_turn", 64'(bus.white_turn), 64'd0);
    p0 = pick_cnt;
    click(458, 250);
    check("t5_go_blocks_pick", 64'(pick_cnt), 64'(p0));
    bus.game_over = 1'b0;

    // 6: hold behaviour with and without the timeout
    q0 = place_cnt;
    click(458, 250);
    check("t6_pick_pos", 64'(pick_pos), 64'd20);
`ifdef MOVE_TIMEOUT_EN
    repeat (40) @(posedge clk); #1;
    check("t6_tmo_place", 64'(place_cnt), 64'(q0 + 1));
    check("t6_tmo_pos", 64'(place_pos), 64'd20);
    check("t6_tmo_delay", 64'(place_cyc - pick_cyc), 64'd17);
    check("t6_tmo_turn", 64'(bus.white_turn), 64'd0);
    click(458, 250);
`else
    repeat (100) @(posedge clk); #1;
    check("t6_hold_persists", 64'(bus.holding), 64'd1);
    check("t6_no_place", 64'(place_cnt), 64'(q0));
`endif

    // 7: reset while holding (black to move)
    q0 = place_cnt;
    check("t7_pre_holding", 64'(bus.holding), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_holding", 64'(bus.holding), 64'd0);
    check("t7_white_turn", 64'(bus.white_turn), 64'd1);
    check("t7_selpos", 64'(bus.sel_pos), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("t7_no_place", 64'(place_cnt), 64'(q0));

    check("never_both_pulses", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
